// File: rtl/axi3_reg_slave.sv
// AXI3 subordinate terminating write/read bursts into a DEPTH-word register array.
// Optional macro AXI3_REG_SLAVE_WRAP_EN enables WRAP burst support.
module axi3_reg_slave #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [3:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [3:0]              arlen,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned BSHIFT = $clog2(STRB_W);
  localparam int unsigned MIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;
`ifdef AXI3_REG_SLAVE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  // Address of the following beat; WRAP stays inside the (len+1)*STRB_W aligned window.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [3:0]            len,
                                                      input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    inc  = addr + ADDR_WIDTH'(STRB_W);
    mask = ADDR_WIDTH'(((32'(len) + 32'd1) << BSHIFT) - 32'd1);
    if (burst == BURST_FIXED)     next_addr = addr;
    else if (burst == BURST_WRAP) next_addr = (addr & ~mask) | (inc & mask);
    else                          next_addr = inc;
  endfunction

  // Bursts the array cannot service: reserved type, WRAP when disabled or with an illegal length.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [3:0] len);
    logic len_ok;
    len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    if (burst == BURST_WRAP) burst_bad = !(WRAP_EN && len_ok);
    else                     burst_bad = burst[1];
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    in_range = (32'(addr >> BSHIFT) < DEPTH);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------- write engine ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [3:0]            wlen_q, wlen_d;
  logic [1:0]            wburst_q, wburst_d;
  logic [3:0]            wbeat_q, wbeat_d;
  logic                  werr_q, werr_d;
  logic                  wdrop_q, wdrop_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  mem_we;
  logic [MIDX_W-1:0]     mem_widx;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) w_state_q <= W_IDLE;
    else           w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (awvalid && awready_q)        w_state_d = W_DATA;
      W_DATA:  if (wvalid && wready_q && wlast) w_state_d = W_RESP;
      W_RESP:  if (bvalid_q && bready)          w_state_d = W_IDLE;
      default:                                  w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    wid_d    = wid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wburst_d = wburst_q;
    wbeat_d  = wbeat_q;
    werr_d   = werr_q;
    wdrop_d  = wdrop_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    mem_we   = 1'b0;
    mem_widx = MIDX_W'(waddr_q >> BSHIFT);
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          wid_d    = awid;
          waddr_d  = awaddr;
          wlen_d   = awlen;
          wburst_d = awburst;
          wbeat_d  = 4'd0;
          werr_d   = burst_bad(awburst, awlen);
          wdrop_d  = burst_bad(awburst, awlen);
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          if (!wdrop_q) begin
            if (in_range(waddr_q)) mem_we = 1'b1;
            else                   werr_d = 1'b1;
          end
          // Short burst is flagged at wlast; an overrun drops every beat past awlen.
          if (wlast) begin
            if (wbeat_q != wlen_q) werr_d = 1'b1;
          end else if (wbeat_q == wlen_q) begin
            werr_d  = 1'b1;
            wdrop_d = 1'b1;
          end
          waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
          wbeat_d = wbeat_q + 4'd1;
          if (wlast) begin
            bid_d   = wid_q;
            bresp_d = werr_d ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      default: ;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wburst_q  <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
      wdrop_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      wdrop_q   <= wdrop_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < int'(STRB_W); b++)
        if (wstrb[b]) mem_q[mem_widx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // ---------------- read engine ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [3:0]            rlen_q, rlen_d;
  logic [1:0]            rburst_q, rburst_d;
  logic [3:0]            rbeat_q, rbeat_d;
  logic                  rbad_q, rbad_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic                  ld;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_bad;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_state_q <= R_IDLE;
    else           r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (arvalid && arready_q)         r_state_d = R_DATA;
      R_DATA:  if (rvalid_q && rready && rlast_q) r_state_d = R_IDLE;
      default:                                   r_state_d = R_IDLE;
    endcase
  end

  // Each beat's word is loaded into rdata_q one cycle ahead, so reads see pre-write values.
  always_comb begin
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rburst_d = rburst_q;
    rbeat_d  = rbeat_q;
    rbad_d   = rbad_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    ld       = 1'b0;
    ld_addr  = raddr_q;
    ld_bad   = rbad_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          ld       = 1'b1;
          ld_addr  = araddr;
          ld_bad   = burst_bad(arburst, arlen);
          rid_d    = arid;
          raddr_d  = araddr;
          rlen_d   = arlen;
          rburst_d = arburst;
          rbad_d   = ld_bad;
          rbeat_d  = 4'd0;
          rlast_d  = (arlen == 4'd0);
        end
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          if (rlast_q) begin
            rlast_d = 1'b0;
          end else begin
            ld      = 1'b1;
            ld_addr = next_addr(raddr_q, rlen_q, rburst_q);
            raddr_d = ld_addr;
            rbeat_d = rbeat_q + 4'd1;
            rlast_d = (rbeat_d == rlen_q);
          end
        end
      end
      default: ;
    endcase
    if (ld) begin
      if (ld_bad || !in_range(ld_addr)) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else begin
        rdata_d = mem_q[MIDX_W'(ld_addr >> BSHIFT)];
        rresp_d = RESP_OKAY;
      end
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rburst_q  <= '0;
      rbeat_q   <= '0;
      rbad_q    <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rbeat_q   <= rbeat_d;
      rbad_q    <= rbad_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi3_reg_slave.sv
// Directed bench for axi3_reg_slave (default parameters); WRAP expectations follow AXI3_REG_SLAVE_WRAP_EN.
module tb_axi3_reg_slave;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [0:0]  awid;
  logic [7:0]  awaddr;
  logic [3:0]  awlen;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [0:0]  arid;
  logic [7:0]  araddr;
  logic [3:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [0:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  axi3_reg_slave dut (
    .aclk(aclk), .areset_n(areset_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  logic [31:0] wd      [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [1:0]  resp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic aw_send(input logic id, input logic [7:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
    logic r = 1'b0;
    int   n = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    while (!r && n < 100) begin
      r = awready;
      tick();
      n++;
    end
    awvalid = 1'b0;
    chk("aw_hs", 32'(r), 32'd1);
  endtask

  task automatic w_send(input int nbeats, input int last_at, input logic [3:0] strb);
    for (int i = 0; i < nbeats; i++) begin
      logic r = 1'b0;
      int   n = 0;
      wdata = wd[i]; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
      while (!r && n < 100) begin
        r = wready;
        tick();
        n++;
      end
      chk("w_hs", 32'(r), 32'd1);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic b_get(input logic exp_id, output logic [1:0] rsp);
    logic       v = 1'b0;
    logic [0:0] id = 1'b0;
    int         n = 0;
    rsp = 2'b00;
    bready = 1'b1;
    while (!v && n < 100) begin
      v = bvalid; id = bid; rsp = bresp;
      tick();
      n++;
    end
    bready = 1'b0;
    chk("b_hs", 32'(v), 32'd1);
    chk("bid", 32'(id), 32'(exp_id));
  endtask

  task automatic write_burst(input logic id, input logic [7:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input logic [3:0] strb, input int last_at,
                             output logic [1:0] rsp);
    aw_send(id, addr, len, burst);
    w_send(last_at + 1, last_at, strb);
    b_get(id, rsp);
  endtask

  task automatic read_burst(input logic id, input logic [7:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input bit toggle);
    logic        r = 1'b0;
    logic        ph = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pd = '0;
    logic        pl = 1'b0;
    int          n = 0;
    int          k = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    while (!r && n < 100) begin
      r = arready;
      tick();
      n++;
    end
    arvalid = 1'b0;
    chk("ar_hs", 32'(r), 32'd1);
    n = 0;
    while (k <= int'(len) && n < 200) begin
      rready = toggle ? ph : 1'b1;
      if (stall) begin
        chk("r_hold_data", rdata, pd);
        chk("r_hold_last", 32'(rlast), 32'(pl));
      end
      if (rvalid && rready) begin
        rd_data[k] = rdata; rd_resp[k] = rresp; rd_last[k] = rlast;
        chk("rid", 32'(rid), 32'(id));
        k++;
      end
      stall = rvalid && !rready;
      pd = rdata; pl = rlast;
      ph = !ph;
      tick();
      n++;
    end
    rready = 1'b0;
    chk("r_beats", 32'(k), 32'(len) + 32'd1);
    chk("r_done", 32'(rvalid), 32'd0);
  endtask

  task automatic chk_read(input string tag, input int nbeats, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
                          input logic [1:0] eresp);
    logic [31:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int i = 0; i < nbeats; i++) begin
      chk($sformatf("%s_rdata%0d", tag, i), rd_data[i], exp[i]);
      chk($sformatf("%s_rresp%0d", tag, i), 32'(rd_resp[i]), 32'(eresp));
      chk($sformatf("%s_rlast%0d", tag, i), 32'(rd_last[i]), 32'(i == nbeats - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    areset_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 16; i++) wd[i] = '0;

    // Reset values, then ready flags appear one cycle after release
    #12;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    #5 areset_n = 1'b1;
    #1;
    chk("rel_awready", 32'(awready), 32'd0);
    tick();
    chk("rel_awready1", 32'(awready), 32'd1);
    chk("rel_arready1", 32'(arready), 32'd1);

    // INCR write of 1..4 at 0x04, then read back
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
    write_burst(1'b1, 8'h04, 4'd3, 2'b01, 4'hF, 3, resp);
    chk("incr_bresp", 32'(resp), 32'd0);
    read_burst(1'b1, 8'h04, 4'd3, 2'b01, 1'b0);
    chk_read("incr", 4, 32'd1, 32'd2, 32'd3, 32'd4, 2'b00);

    // Byte strobes on word 0
    wd[0] = 32'hAABBCCDD;
    write_burst(1'b0, 8'h00, 4'd0, 2'b01, 4'hF, 0, resp);
    wd[0] = 32'h11223344;
    write_burst(1'b0, 8'h00, 4'd0, 2'b01, 4'b0101, 0, resp);
    chk("strb_bresp", 32'(resp), 32'd0);
    read_burst(1'b0, 8'h00, 4'd0, 2'b01, 1'b0);
    chk_read("strb", 1, 32'hAA22CC44, 32'd0, 32'd0, 32'd0, 2'b00);

    // Burst running past the last word
    wd[0] = 32'h5555AAAA; wd[1] = 32'h12345678;
    write_burst(1'b1, 8'h3C, 4'd1, 2'b01, 4'hF, 1, resp);
    chk("range_bresp", 32'(resp), 32'd2);
    read_burst(1'b1, 8'h3C, 4'd1, 2'b01, 1'b0);
    chk("range_rdata0", rd_data[0], 32'h5555AAAA);
    chk("range_rresp0", 32'(rd_resp[0]), 32'd0);
    chk("range_rlast0", 32'(rd_last[0]), 32'd0);
    chk("range_rdata1", rd_data[1], 32'd0);
    chk("range_rresp1", 32'(rd_resp[1]), 32'd2);
    chk("range_rlast1", 32'(rd_last[1]), 32'd1);

    // Early wlast on a 4-beat burst: two beats land, SLVERR
    wd[0] = 32'hE0; wd[1] = 32'hE1;
    write_burst(1'b0, 8'h30, 4'd3, 2'b01, 4'hF, 1, resp);
    chk("early_bresp", 32'(resp), 32'd2);
    read_burst(1'b0, 8'h30, 4'd1, 2'b01, 1'b0);
    chk_read("early", 2, 32'hE0, 32'hE1, 32'd0, 32'd0, 2'b00);

    // FIXED burst: all beats hit one word, last one wins
    wd[0] = 32'hF0; wd[1] = 32'hF1; wd[2] = 32'hF2;
    write_burst(1'b0, 8'h28, 4'd2, 2'b00, 4'hF, 2, resp);
    chk("fixed_bresp", 32'(resp), 32'd0);
    read_burst(1'b0, 8'h24, 4'd1, 2'b01, 1'b0);
    chk_read("fixed", 2, 32'd0, 32'hF2, 32'd0, 32'd0, 2'b00);

    // B backpressure: bvalid/bid held while bready low
    wd[0] = 32'hB0B0;
    aw_send(1'b1, 8'h20, 4'd0, 2'b01);
    w_send(1, 0, 4'hF);
    for (int c = 0; c < 5; c++) begin
      chk("bp_bvalid", 32'(bvalid), 32'd1);
      chk("bp_bid", 32'(bid), 32'd1);
      tick();
    end
    b_get(1'b1, resp);
    chk("bp_bresp", 32'(resp), 32'd0);
    // R backpressure with rready toggling
    read_burst(1'b0, 8'h04, 4'd3, 2'b01, 1'b1);
    chk_read("rbp", 4, 32'd1, 32'd2, 32'd3, 32'd4, 2'b00);
    read_burst(1'b1, 8'h20, 4'd0, 2'b01, 1'b1);
    chk_read("bpw", 1, 32'hB0B0, 32'd0, 32'd0, 32'd0, 2'b00);

    // WRAP at 0x08, 4 beats over a 16-byte window
    wd[0] = 32'h10; wd[1] = 32'h11; wd[2] = 32'h12; wd[3] = 32'h13;
    write_burst(1'b0, 8'h00, 4'd3, 2'b01, 4'hF, 3, resp);
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    write_burst(1'b0, 8'h08, 4'd3, 2'b10, 4'hF, 3, resp);
`ifdef AXI3_REG_SLAVE_WRAP_EN
    chk("wrap_bresp", 32'(resp), 32'd0);
    read_burst(1'b0, 8'h00, 4'd3, 2'b01, 1'b0);
    chk_read("wrap_mem", 4, 32'hA2, 32'hA3, 32'hA0, 32'hA1, 2'b00);
    read_burst(1'b1, 8'h08, 4'd3, 2'b10, 1'b0);
    chk_read("wrap_rd", 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 2'b00);
    write_burst(1'b0, 8'h00, 4'd2, 2'b10, 4'hF, 2, resp);
    chk("wrap_len_bresp", 32'(resp), 32'd2);
`else
    chk("wrap_bresp", 32'(resp), 32'd2);
    read_burst(1'b0, 8'h00, 4'd3, 2'b01, 1'b0);
    chk_read("wrap_mem", 4, 32'h10, 32'h11, 32'h12, 32'h13, 2'b00);
    read_burst(1'b1, 8'h08, 4'd3, 2'b10, 1'b0);
    chk_read("wrap_rd", 4, 32'd0, 32'd0, 32'd0, 32'd0, 2'b10);
`endif

    // Reset during beat 2 of a 4-beat INCR write
    wd[0] = 32'hDEAD0001; wd[1] = 32'hDEAD0002;
    aw_send(1'b1, 8'h04, 4'd3, 2'b01);
    w_send(2, 3, 4'hF);
    wdata = 32'hDEAD0003; wstrb = 4'hF; wvalid = 1'b1;
    #2 areset_n = 1'b0;
    #1;
    chk("mid_awready", 32'(awready), 32'd0);
    chk("mid_wready", 32'(wready), 32'd0);
    chk("mid_bvalid", 32'(bvalid), 32'd0);
    chk("mid_bid", 32'(bid), 32'd0);
    chk("mid_bresp", 32'(bresp), 32'd0);
    chk("mid_arready", 32'(arready), 32'd0);
    chk("mid_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rlast", 32'(rlast), 32'd0);
    chk("mid_rid", 32'(rid), 32'd0);
    chk("mid_rresp", 32'(rresp), 32'd0);
    chk("mid_rdata", rdata, 32'd0);
    wvalid = 1'b0;
    @(posedge aclk);
    #2 areset_n = 1'b1;
    tick();
    read_burst(1'b0, 8'h00, 4'd3, 2'b01, 1'b0);
    chk_read("post_rst", 4, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00);
    read_burst(1'b0, 8'h3C, 4'd0, 2'b01, 1'b0);
    chk_read("post_rst15", 1, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
